// File: rtl/pifo_calendar_pkg.sv
// pifo_calendar_pkg: element word layout shared by the calendar controller
// and the PIFO atoms, plus a helper that packs an element.
package pifo_calendar_pkg;

    localparam int ELEM_W         = 32;
    localparam int RANK_W         = 19;
    localparam int ADDR_W         = 12;
    localparam int VALID_POS      = 31;
    localparam int RANK_START_POS = 12;
    localparam int RANK_END_POS   = 30;

    typedef logic [ELEM_W-1:0] element_t;
    typedef logic [RANK_W-1:0] rank_t;
    typedef logic [ADDR_W-1:0] addr_t;

    function automatic element_t make_element(
        input rank_t rank,
        input addr_t addr
    );
        return {1'b1, rank, addr};
    endfunction

endpackage

// File: rtl/pifo_cal_stats.sv
// pifo_cal_stats: enqueue/dequeue/bypass event counters and occupancy
// high-water mark for the calendar controller (PIFO_CAL_STATS_EN builds).
module pifo_cal_stats #(
    parameter int CNT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enq,
    input  logic                 deq,
    input  logic                 bypass,
    input  logic [CNT_WIDTH-1:0] occupancy,
    output logic [31:0]          stat_enq_cnt,
    output logic [31:0]          stat_deq_cnt,
    output logic [31:0]          stat_bypass_cnt,
    output logic [CNT_WIDTH-1:0] stat_high_water
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stat_enq_cnt    <= '0;
            stat_deq_cnt    <= '0;
            stat_bypass_cnt <= '0;
            stat_high_water <= '0;
        end else begin
            if (enq)
                stat_enq_cnt <= stat_enq_cnt + 32'd1;
            if (deq)
                stat_deq_cnt <= stat_deq_cnt + 32'd1;
            if (bypass)
                stat_bypass_cnt <= stat_bypass_cnt + 32'd1;
            if (occupancy > stat_high_water)
                stat_high_water <= occupancy;
        end
    end

endmodule

// File: rtl/pifo_calendar_ctrl.sv
// pifo_calendar_ctrl: enqueue/pop front-end for the PIFO calendar atom chain.
// Define PIFO_CAL_STATS_EN to add the stat_* counter outputs.
module pifo_calendar_ctrl
    import pifo_calendar_pkg::*;
#(
    parameter int DEPTH              = 16,
    parameter int ELEMENT_WIDTH      = 32,
    parameter int ELEMENT_RANK_WIDTH = 19,
    parameter int ADDR_WIDTH         = 12,
    parameter int CNT_WIDTH          = 5
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          s_enq_valid,
    output logic                          s_enq_ready,
    input  logic [ELEMENT_RANK_WIDTH-1:0] s_enq_rank,
    input  logic [ADDR_WIDTH-1:0]         s_enq_addr,
    input  logic                          pop_req,
    input  logic [ELEMENT_WIDTH-1:0]      in_pifo_head,
    output logic [ELEMENT_WIDTH-1:0]      out_pifo_input,
    output logic                          out_ctl_insert,
    output logic                          out_ctl_pop,
    output logic                          m_deq_valid,
    output logic [ELEMENT_RANK_WIDTH-1:0] m_deq_rank,
    output logic [ADDR_WIDTH-1:0]         m_deq_addr,
    output logic [CNT_WIDTH-1:0]          occupancy,
    output logic                          full,
    output logic                          empty,
    output logic                          pop_err
`ifdef PIFO_CAL_STATS_EN
    ,
    output logic [31:0]                   stat_enq_cnt,
    output logic [31:0]                   stat_deq_cnt,
    output logic [31:0]                   stat_bypass_cnt,
    output logic [CNT_WIDTH-1:0]          stat_high_water
`endif
);

    logic                          enq;
    logic                          pop_ok;
    logic                          bypass;
    logic                          arr_ins;
    logic                          arr_pop;
    logic [ELEMENT_RANK_WIDTH-1:0] head_rank;
    logic                          unused_head_valid;

    assign head_rank         = in_pifo_head[RANK_END_POS:RANK_START_POS];
    assign unused_head_valid = in_pifo_head[VALID_POS];

    assign empty  = (occupancy == '0);
    assign full   = (occupancy == CNT_WIDTH'(DEPTH));
    assign pop_ok = pop_req & ~empty;

    // A pop in the same cycle frees the slot, so a full array still accepts.
    assign s_enq_ready = ~full | pop_ok;
    assign enq         = s_enq_valid & s_enq_ready;

    // Ties favour the resident head, keeping equal ranks in arrival order.
    assign bypass  = enq & pop_req & (empty | (s_enq_rank < head_rank));
    assign arr_ins = enq & ~bypass;
    assign arr_pop = pop_ok & ~bypass;

    assign out_pifo_input = make_element(s_enq_rank, s_enq_addr);
    assign out_ctl_insert = rstn & arr_ins;
    assign out_ctl_pop    = rstn & arr_pop;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            occupancy   <= '0;
            m_deq_valid <= 1'b0;
            m_deq_rank  <= '0;
            m_deq_addr  <= '0;
            pop_err     <= 1'b0;
        end else begin
            m_deq_valid <= arr_pop | bypass;
            pop_err     <= pop_req & empty & ~enq;
            if (bypass) begin
                m_deq_rank <= s_enq_rank;
                m_deq_addr <= s_enq_addr;
            end else if (arr_pop) begin
                m_deq_rank <= head_rank;
                m_deq_addr <= in_pifo_head[ADDR_WIDTH-1:0];
            end
            unique case ({arr_ins, arr_pop})
                2'b10:   occupancy <= occupancy + CNT_WIDTH'(1);
                2'b01:   occupancy <= occupancy - CNT_WIDTH'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

`ifdef PIFO_CAL_STATS_EN
    pifo_cal_stats #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_stats (
        .clk            (clk),
        .rstn           (rstn),
        .enq            (enq),
        .deq            (arr_pop | bypass),
        .bypass         (bypass),
        .occupancy      (occupancy),
        .stat_enq_cnt   (stat_enq_cnt),
        .stat_deq_cnt   (stat_deq_cnt),
        .stat_bypass_cnt(stat_bypass_cnt),
        .stat_high_water(stat_high_water)
    );
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pifo_calendar_ctrl.sv
// tb_pifo_calendar_ctrl: directed table, corner sequences and random traffic
// checked against a sorted-queue model of the controller plus atom chain.
module tb_pifo_calendar_ctrl;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        s_enq_valid;
    logic        s_enq_ready;
    logic [18:0] s_enq_rank;
    logic [11:0] s_enq_addr;
    logic        pop_req;
    logic [31:0] in_pifo_head;
    logic [31:0] out_pifo_input;
    logic        out_ctl_insert;
    logic        out_ctl_pop;
    logic        m_deq_valid;
    logic [18:0] m_deq_rank;
    logic [11:0] m_deq_addr;
    logic [4:0]  occupancy;
    logic        full;
    logic        empty;
    logic        pop_err;

    always #5 clk = ~clk;

    pifo_calendar_ctrl dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_enq_valid   (s_enq_valid),
        .s_enq_ready   (s_enq_ready),
        .s_enq_rank    (s_enq_rank),
        .s_enq_addr    (s_enq_addr),
        .pop_req       (pop_req),
        .in_pifo_head  (in_pifo_head),
        .out_pifo_input(out_pifo_input),
        .out_ctl_insert(out_ctl_insert),
        .out_ctl_pop   (out_ctl_pop),
        .m_deq_valid   (m_deq_valid),
        .m_deq_rank    (m_deq_rank),
        .m_deq_addr    (m_deq_addr),
        .occupancy     (occupancy),
        .full          (full),
        .empty         (empty),
        .pop_err       (pop_err)
    );

    typedef struct {
        logic [18:0] rank;
        logic [11:0] addr;
    } ent_t;

    typedef struct {
        bit v;
        int rank;
        int addr;
        bit pop;
        bit e_rdy;
        bit e_ins;
        bit e_pop;
        bit e_dv;
        int e_dr;
        int e_da;
        int e_occ;
        bit e_err;
    } vec_t;

    // Model: the atom chain as a rank-sorted queue, plus the registered outputs.
    ent_t        q[$];
    logic        m_dv;
    logic        m_err;
    logic [18:0] m_dr;
    logic [11:0] m_da;

    int checks = 0;
    int errors = 0;

    logic        s_ready, s_ins, s_pop, s_dv, s_err;
    logic [18:0] s_dr;
    logic [11:0] s_da;
    logic [4:0]  s_occ;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive_head();
        if (q.size() == 0)
            in_pifo_head = '0;
        else
            in_pifo_head = {1'b1, q[0].rank, q[0].addr};
    endtask

    task automatic cycle();
        bit   emp, ful, rdy, enq, byp, ins, pp;
        int   idx;
        ent_t e;
        @(negedge clk);
        emp = (q.size() == 0);
        ful = (q.size() == DEPTH);
        rdy = !ful || (pop_req && !emp);
        enq = s_enq_valid && rdy;
        byp = enq && pop_req && (emp || (s_enq_rank < q[0].rank));
        ins = enq && !byp;
        pp  = pop_req && !emp && !byp;
        chk("ready", s_enq_ready, rdy);
        chk("ctl_insert", out_ctl_insert, ins && rstn);
        chk("ctl_pop", out_ctl_pop, pp && rstn);
        chk("pifo_input", out_pifo_input, {1'b1, s_enq_rank, s_enq_addr});
        chk("occupancy", occupancy, q.size());
        chk("full", full, ful);
        chk("empty", empty, emp);
        chk("deq_valid", m_deq_valid, m_dv);
        chk("pop_err", pop_err, m_err);
        if (m_dv) begin
            chk("deq_rank", m_deq_rank, m_dr);
            chk("deq_addr", m_deq_addr, m_da);
        end
        s_ready = s_enq_ready; s_ins = out_ctl_insert; s_pop = out_ctl_pop;
        s_dv = m_deq_valid; s_err = pop_err; s_dr = m_deq_rank;
        s_da = m_deq_addr; s_occ = occupancy;
        @(posedge clk);
        if (!rstn) begin
            q.delete();
            m_dv = 0; m_err = 0; m_dr = 0; m_da = 0;
        end else begin
            m_dv  = pp || byp;
            m_err = pop_req && emp && !enq;
            if (byp) begin
                m_dr = s_enq_rank; m_da = s_enq_addr;
            end else if (pp) begin
                m_dr = q[0].rank; m_da = q[0].addr;
            end
            if (pp) void'(q.pop_front());
            if (ins) begin
                e.rank = s_enq_rank; e.addr = s_enq_addr;
                idx = q.size();
                for (int i = 0; i < q.size(); i++)
                    if (q[i].rank > s_enq_rank) begin idx = i; break; end
                q.insert(idx, e);
            end
        end
        #1;
        drive_head();
    endtask

    task automatic drive(input bit v, input int rank, input int addr,
                         input bit pop);
        s_enq_valid = v;
        s_enq_rank  = 19'(rank);
        s_enq_addr  = 12'(addr);
        pop_req     = pop;
    endtask

    function automatic vec_t mk(bit v, int r, int a, bit p, bit rdy, bit ins,
                                bit pp, bit dv, int dr, int da, int occ,
                                bit err);
        vec_t t;
        t.v = v; t.rank = r; t.addr = a; t.pop = p;
        t.e_rdy = rdy; t.e_ins = ins; t.e_pop = pp; t.e_dv = dv;
        t.e_dr = dr; t.e_da = da; t.e_occ = occ; t.e_err = err;
        return t;
    endfunction

    initial begin
        m_dv = 0; m_err = 0; m_dr = 0; m_da = 0;
        rstn = 1'b0;
        drive(0, 0, 0, 0);
        in_pifo_head = '0;
        tbl[0]  = mk(1, 30, 1, 0, 1, 1, 0, 0,  0, 0, 0, 0);
        tbl[1]  = mk(1, 10, 2, 0, 1, 1, 0, 0,  0, 0, 1, 0);
        tbl[2]  = mk(1, 20, 3, 0, 1, 1, 0, 0,  0, 0, 2, 0);
        tbl[3]  = mk(0,  0, 0, 1, 1, 0, 1, 0,  0, 0, 3, 0);
        tbl[4]  = mk(0,  0, 0, 1, 1, 0, 1, 1, 10, 2, 2, 0);
        tbl[5]  = mk(0,  0, 0, 1, 1, 0, 1, 1, 20, 3, 1, 0);
        tbl[6]  = mk(0,  0, 0, 0, 1, 0, 0, 1, 30, 1, 0, 0);
        tbl[7]  = mk(1,  8, 1, 0, 1, 1, 0, 0,  0, 0, 0, 0);
        tbl[8]  = mk(1,  8, 2, 0, 1, 1, 0, 0,  0, 0, 1, 0);
        tbl[9]  = mk(0,  0, 0, 1, 1, 0, 1, 0,  0, 0, 2, 0);
        tbl[10] = mk(0,  0, 0, 1, 1, 0, 1, 1,  8, 1, 1, 0);
        tbl[11] = mk(0,  0, 0, 0, 1, 0, 0, 1,  8, 2, 0, 0);
        tbl[12] = mk(0,  0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0);
        tbl[13] = mk(0,  0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1);
        tbl[14] = mk(1,  4, 9, 1, 1, 0, 0, 0,  0, 0, 0, 0);
        tbl[15] = mk(0,  0, 0, 0, 1, 0, 0, 1,  4, 9, 0, 0);
        tbl[16] = mk(0,  0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0);

        #1;
        cycle();
        cycle();
        rstn = 1'b1;
        chk("rst_occ", occupancy, 0);
        chk("rst_dv", m_deq_valid, 0);
        chk("rst_rank", m_deq_rank, 0);
        chk("rst_addr", m_deq_addr, 0);
        chk("rst_err", pop_err, 0);
        chk("rst_empty", empty, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].rank, tbl[i].addr, tbl[i].pop);
            cycle();
            chk($sformatf("v%0d_rdy", i), s_ready, tbl[i].e_rdy);
            chk($sformatf("v%0d_ins", i), s_ins, tbl[i].e_ins);
            chk($sformatf("v%0d_pop", i), s_pop, tbl[i].e_pop);
            chk($sformatf("v%0d_dv", i), s_dv, tbl[i].e_dv);
            chk($sformatf("v%0d_occ", i), s_occ, tbl[i].e_occ);
            chk($sformatf("v%0d_err", i), s_err, tbl[i].e_err);
            if (tbl[i].e_dv) begin
                chk($sformatf("v%0d_dr", i), s_dr, tbl[i].e_dr);
                chk($sformatf("v%0d_da", i), s_da, tbl[i].e_da);
            end
        end

        // Fill to DEPTH with ranks 7..22, then probe back-pressure.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 7 + i, 100 + i, 0);
            cycle();
        end
        drive(0, 0, 0, 0);
        cycle();
        chk("fill_full", full, 1);
        chk("fill_occ", occupancy, DEPTH);
        drive(1, 50, 50, 0);
        cycle();
        chk("full_ready", s_ready, 0);
        chk("full_noins", s_ins, 0);
        drive(0, 0, 0, 0);
        cycle();
        drive(1, 5, 'h55, 1);
        cycle();
        chk("byp_ready", s_ready, 1);
        chk("byp_ins", s_ins, 0);
        chk("byp_pop", s_pop, 0);
        drive(0, 0, 0, 0);
        cycle();
        chk("byp_dv", s_dv, 1);
        chk("byp_rank", s_dr, 5);
        chk("byp_addr", s_da, 'h55);
        chk("byp_occ", s_occ, DEPTH);
        drive(1, 9, 'h99, 1);
        cycle();
        chk("ip_ins", s_ins, 1);
        chk("ip_pop", s_pop, 1);
        drive(0, 0, 0, 0);
        cycle();
        chk("ip_dv", s_dv, 1);
        chk("ip_rank", s_dr, 7);
        chk("ip_addr", s_da, 100);
        chk("ip_occ", s_occ, DEPTH);

        // Drain to 5, leave a dequeue in flight, then reset.
        for (int i = 0; i < DEPTH - 5; i++) begin
            drive(0, 0, 0, 1);
            cycle();
        end
        chk("drain_occ", occupancy, 5);
        cycle();
        rstn = 1'b0;
        drive(1, 1, 1, 1);
        cycle();
        chk("rst_ins", s_ins, 0);
        chk("rst_pop", s_pop, 0);
        rstn = 1'b1;
        drive(0, 0, 0, 0);
        cycle();
        chk("post_rst_dv", s_dv, 0);
        chk("post_rst_occ", s_occ, 0);
        chk("post_rst_rank", s_dr, 0);

        // Random traffic; a stalled enqueue keeps its fields until accepted.
        for (int i = 0; i < 3000; i++) begin
            int enq_pct;
            enq_pct = ((i / 400) % 2 == 0) ? 70 : 35;
            rstn = ($urandom_range(0, 299) != 0);
            if (!(s_enq_valid && !s_ready)) begin
                s_enq_valid = ($urandom_range(0, 99) < enq_pct);
                s_enq_rank  = 19'($urandom_range(0, 40));
                s_enq_addr  = 12'($urandom);
            end
            pop_req = ($urandom_range(0, 99) < 50);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
